// File: rtl/imm_extend_pipe.sv
// Decode-stage immediate extender with a registered valid/ready output and a one-entry skid buffer.
// Optional output-handshake counter enabled by defining IMM_PERF_CNT_EN.
module imm_extend_pipe #(
    parameter int INTEGER_WIDTH = 32,
    parameter int IMM_WIDTH     = 19,
    parameter int SHAMT         = 2,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IMM_WIDTH-1:0]     in_imm,
    input  logic [1:0]               in_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INTEGER_WIDTH-1:0] out_imm
`ifdef IMM_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]     out_xfer_cnt
`endif
);

    localparam int PAD = INTEGER_WIDTH - IMM_WIDTH;

    if (IMM_WIDTH >= INTEGER_WIDTH || IMM_WIDTH + SHAMT > INTEGER_WIDTH || CNT_WIDTH < 1) begin : g_bad_params
        $error("imm_extend_pipe: illegal parameter combination");
    end

    logic                     oreg_valid_q, oreg_valid_d;
    logic [INTEGER_WIDTH-1:0] oreg_data_q,  oreg_data_d;
    logic                     skid_valid_q, skid_valid_d;
    logic [INTEGER_WIDTH-1:0] skid_data_q,  skid_data_d;
    logic [INTEGER_WIDTH-1:0] sext_imm;
    logic [INTEGER_WIDTH-1:0] ext_imm;
    logic                     accept;
    logic                     pop;

    always_comb begin
        sext_imm = {{PAD{in_imm[IMM_WIDTH-1]}}, in_imm};
        ext_imm  = sext_imm;
        case (in_mode)
            2'b00:   ext_imm = sext_imm;
            2'b01:   ext_imm = {{PAD{1'b0}}, in_imm};
            2'b10:   ext_imm = sext_imm << SHAMT;
            default: ext_imm = {in_imm, {PAD{1'b0}}};
        endcase
    end

    // in_ready depends only on registered state so out_ready never reaches it combinationally.
    assign in_ready  = !skid_valid_q;
    assign accept    = in_valid && in_ready;
    assign pop       = oreg_valid_q && out_ready;
    assign out_valid = oreg_valid_q;
    assign out_imm   = oreg_data_q;

    always_comb begin
        oreg_valid_d = oreg_valid_q;
        oreg_data_d  = oreg_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            oreg_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!oreg_valid_q || pop) begin
            // OREG is free this cycle: the skid entry is older than any new input.
            if (skid_valid_q) begin
                oreg_valid_d = 1'b1;
                oreg_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                oreg_valid_d = 1'b1;
                oreg_data_d  = ext_imm;
            end else begin
                oreg_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = ext_imm;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oreg_valid_q <= 1'b0;
            oreg_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            oreg_valid_q <= oreg_valid_d;
            oreg_data_q  <= oreg_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

`ifdef IMM_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (pop && (cnt_q != {CNT_WIDTH{1'b1}})) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out_xfer_cnt = cnt_q;
`endif

endmodule
